// File: rtl/dpram_be_clr.sv
// Simple dual-port RAM with byte-enabled writes, write-first read bypass and a self-clearing sweep FSM.
// Read latency 1 cycle; re/we/clr_req are ignored while busy (clear sweep) is high.
module dpram_be_clr #(
    parameter int                ADDR_W  = 5,
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   raddr,
    input  logic                re,
    output logic [DATA_W-1:0]   dataout,
    output logic                dvalid,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   datain,
    input  logic                we,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic                clr_req,
    output logic                busy
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_merged;
    logic              wr_act;
    logic              rd_act;

    assign wr_act = (state == READY) && we;
    assign rd_act = (state == READY) && re;

    // Sweep ends on the all-ones pointer, so the counter never needs an extra bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (&clr_ptr) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= CLR_VAL;
        end else if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) mem[waddr][8*i +: 8] <= datain[8*i +: 8];
            end
        end
    end

    // Write-first: enabled bytes of a same-address write override the stored word.
    always_comb begin
        rd_merged = mem[raddr];
        for (int i = 0; i < NB; i++) begin
            if (wr_act && (waddr == raddr) && wbe[i]) rd_merged[8*i +: 8] = datain[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dataout <= '0;
            dvalid  <= 1'b0;
        end else begin
            dvalid <= rd_act;
            if (rd_act) dataout <= rd_merged;
        end
    end
endmodule
